// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode 0 frame controller for the 16-bit register-write link
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       cs_n,
    output logic       copi,
    input  logic       cipo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TAIL,
        S_GAP
    } state_t;

    // TAIL covers the low half of the last sclk period plus one trailing
    // half-period, so cs_n is low for 34 half-periods in total.
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] TAIL_LAST = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [3:0]  bit_idx;
    logic [15:0] shreg;
    logic        rw_q;
    logic [7:0]  rd_shift;
    logic        accept;
    logic        frame_end;

    // copi is the top bit of the shift register; it is cleared outside a frame
    assign copi = shreg[15];

    // Next-state decode. The final GAP cycle also samples start so that a held
    // start produces frames separated by exactly CS_GAP cycles of cs_n high.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_LEAD;
            S_LEAD: if (cnt == HALF_LAST) next_state = S_HIGH;
            S_HIGH: if (cnt == HALF_LAST) next_state = (bit_idx == 4'd0) ? S_TAIL : S_LOW;
            S_LOW:  if (cnt == HALF_LAST) next_state = S_HIGH;
            S_TAIL: if (cnt == TAIL_LAST) next_state = S_GAP;
            S_GAP:  if (cnt == GAP_LAST) next_state = start ? S_LEAD : S_IDLE;
            default: next_state = S_IDLE;
        endcase
        accept    = (next_state == S_LEAD) && ((state == S_IDLE) || (state == S_GAP));
        frame_end = (state == S_TAIL) && (next_state == S_GAP);
    end

    // State register and per-state cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if ((next_state != state) || (state == S_IDLE))
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
        end
    end

    // Registered outputs, frame shift register and read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            shreg    <= '0;
            bit_idx  <= '0;
            rw_q     <= 1'b0;
            rd_shift <= '0;
        end else begin
            sclk <= (next_state == S_HIGH);
            cs_n <= !((next_state == S_LEAD) || (next_state == S_HIGH) ||
                      (next_state == S_LOW)  || (next_state == S_TAIL));
            busy <= (next_state != S_IDLE);
            done <= frame_end;

            if (accept) begin
                shreg   <= {rw, addr, wdata};
                rw_q    <= rw;
                bit_idx <= 4'd15;
            end else if ((state == S_HIGH) && (next_state == S_LOW)) begin
                shreg   <= {shreg[14:0], 1'b0};
                bit_idx <= bit_idx - 4'd1;
            end else if (frame_end) begin
                shreg <= '0;
            end

            // cipo is sampled on the cycle sclk rises, data phase of reads only
            if ((state == S_HIGH) && (cnt == 16'd0) && !rw_q && (bit_idx <= 4'd7))
                rd_shift <= {rd_shift[6:0], cipo};

            if (frame_end && !rw_q)
                rdata <= rd_shift;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller
module tb_spi_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, rw, cipo;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, sclk, cs_n, copi;
    logic [7:0] rdata;

    logic       rst2, start2, rw2, cipo2;
    logic [6:0] addr2;
    logic [7:0] wdata2;
    logic       busy2, done2, sclk2, cs_n2, copi2;
    logic [7:0] rdata2;

    spi_controller #(.CLK_DIV(4), .CS_GAP(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .cs_n(cs_n),
        .copi(copi), .cipo(cipo)
    );

    spi_controller #(.CLK_DIV(1), .CS_GAP(1)) u_dut_fast (
        .clk(clk), .rst(rst2), .start(start2), .rw(rw2), .addr(addr2), .wdata(wdata2),
        .busy(busy2), .done(done2), .rdata(rdata2), .sclk(sclk2), .cs_n(cs_n2),
        .copi(copi2), .cipo(cipo2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Peripheral-side model: decodes frames seen on the wire, drives cipo on sclk falls
    typedef struct {
        logic        prev_sclk;
        logic        prev_cs;
        int          rises;
        int          cs_low;
        int          high_run;
        int          frames;
        int          last_rises;
        int          last_cs_low;
        int          last_high_run;
        int          total_rises;
        logic [15:0] word;
        logic [15:0] last_word;
        logic [7:0]  rd_val;
        logic        cipo;
        logic        wr_pending;
    } mon_t;

    function automatic mon_t mon_init();
        mon_t m;
        m.prev_sclk = 1'b0; m.prev_cs = 1'b1;
        m.rises = 0; m.cs_low = 0; m.high_run = 0; m.frames = 0;
        m.last_rises = 0; m.last_cs_low = 0; m.last_high_run = 0; m.total_rises = 0;
        m.word = '0; m.last_word = '0; m.rd_val = '0; m.cipo = 1'b0; m.wr_pending = 1'b0;
        return m;
    endfunction

    function automatic void mon_step(inout mon_t m, input logic s, input logic cs, input logic d);
        int idx;
        if (cs && !m.prev_cs) begin
            m.last_word   = m.word;
            m.last_rises  = m.rises;
            m.last_cs_low = m.cs_low;
            m.wr_pending  = (m.rises == 16) && m.word[15];
            m.frames++;
            m.high_run = 0;
            m.cipo     = 1'b0;
        end
        if (!cs && m.prev_cs) begin
            m.last_high_run = m.high_run;
            m.rises  = 0;
            m.word   = '0;
            m.cs_low = 0;
            m.cipo   = 1'b0;
        end
        if (cs) m.high_run++;
        else    m.cs_low++;
        if (!cs && s && !m.prev_sclk) begin
            m.word = {m.word[14:0], d};
            m.rises++;
            m.total_rises++;
        end
        if (!cs && !s && m.prev_sclk) begin
            idx    = 15 - m.rises;
            m.cipo = (idx >= 0 && idx <= 7) ? m.rd_val[idx[2:0]] : 1'b0;
        end
        m.prev_sclk = s;
        m.prev_cs   = cs;
    endfunction

    mon_t       m1, m2;
    logic [7:0] regs [0:127];
    int         dones = 0;

    initial begin
        m1 = mon_init();
        m2 = mon_init();
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    end

    always @(negedge clk) begin
        mon_step(m1, sclk, cs_n, copi);
        cipo = m1.cipo;
        if (m1.wr_pending) begin
            regs[m1.last_word[14:8]] = m1.last_word[7:0];
            m1.wr_pending = 1'b0;
        end
        if (done) dones++;
        mon_step(m2, sclk2, cs_n2, copi2);
        cipo2 = m2.cipo;
    end

    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                             output int busy_after, output logic [7:0] rd_at_done);
        int k;
        @(negedge clk);
        start = 1'b1; rw = r; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
        k = 0;
        while (!done && k < 2000) begin @(negedge clk); k++; end
        check("done_seen", 32'(done), 32'd1);
        rd_at_done = rdata;
        busy_after = 0;
        while (busy && busy_after < 100) begin @(negedge clk); busy_after++; end
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] wr_data [4];
    int         b, k, base_frames, base_rises, base_dones;
    logic [7:0] rd;

    initial begin
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        rst2 = 1'b1; start2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0;
        wr_data[0] = 8'hAA; wr_data[1] = 8'h55; wr_data[2] = 8'h0F; wr_data[3] = 8'h80;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_cs_n",  32'(cs_n),  32'd1);
        check("rst_copi",  32'(copi),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        start = 1'b0; rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        base_dones = dones;
        run_frame(1'b1, 7'h00, 8'hF0, b, rd);
        check("w0_word",   32'(m1.last_word),   32'h80F0);
        check("w0_cs_low", 32'(m1.last_cs_low), 32'd136);
        check("w0_rises",  32'(m1.last_rises),  32'd16);
        check("w0_dones",  32'(dones - base_dones), 32'd1);
        check("w0_busy_after_done", 32'(b), 32'd4);
        check("w0_reg0",   32'(regs[0]), 32'hF0);

        for (int i = 0; i < 4; i++) run_frame(1'b1, 7'(i + 1), wr_data[i], b, rd);
        check("reg1", 32'(regs[1]), 32'hAA);
        check("reg2", 32'(regs[2]), 32'h55);
        check("reg3", 32'(regs[3]), 32'h0F);
        check("reg4", 32'(regs[4]), 32'h80);
        check("reg0_kept", 32'(regs[0]), 32'hF0);
        check("reg5_kept", 32'(regs[5]), 32'h00);

        m1.rd_val = 8'hA5;
        run_frame(1'b0, 7'h04, 8'h00, b, rd);
        check("rd_word",    32'(m1.last_word), 32'h0400);
        check("rd_at_done", 32'(rd), 32'hA5);
        check("rd_reg4",    32'(regs[4]), 32'h80);
        run_frame(1'b1, 7'h05, 8'h11, b, rd);
        check("rdata_after_write", 32'(rdata), 32'hA5);
        check("reg5", 32'(regs[5]), 32'h11);

        base_frames = m1.frames; base_rises = m1.total_rises;
        @(negedge clk); start = 1'b1; rw = 1'b1; addr = 7'h06; wdata = 8'h66;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0; while (busy && k < 1000) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        check("pulse_frames", 32'(m1.frames - base_frames), 32'd1);
        check("pulse_rises",  32'(m1.total_rises - base_rises), 32'd16);

        base_frames = m1.frames;
        @(negedge clk); start = 1'b1; rw = 1'b1; addr = 7'h07; wdata = 8'h77;
        k = 0; while (m1.frames != base_frames + 1 && k < 1000) begin @(negedge clk); k++; end
        k = 0; while (cs_n && k < 50) begin @(negedge clk); k++; end
        start = 1'b0;
        k = 0; while (busy && k < 1000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        check("held_frames",  32'(m1.frames - base_frames), 32'd2);
        check("held_cs_high", 32'(m1.last_high_run), 32'd4);
        check("held_reg7",    32'(regs[7]), 32'h77);

        base_dones = dones;
        @(negedge clk); start = 1'b1; rw = 1'b1; addr = 7'h02; wdata = 8'h99;
        @(negedge clk); start = 1'b0;
        k = 0; while (m1.rises != 6 && k < 500) begin @(negedge clk); k++; end
        check("midrst_in_high", 32'(sclk), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_copi", 32'(copi), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(dones - base_dones), 32'd0);
        check("midrst_reg2_kept", 32'(regs[2]), 32'h55);
        run_frame(1'b1, 7'h02, 8'h33, b, rd);
        check("after_rst_word", 32'(m1.last_word), 32'h8233);
        check("after_rst_reg2", 32'(regs[2]), 32'h33);

        @(negedge clk); start2 = 1'b1; rw2 = 1'b1; addr2 = 7'h03; wdata2 = 8'h7E;
        @(negedge clk); start2 = 1'b0; addr2 = 7'h00; wdata2 = 8'h00;
        k = 0; while (busy2 && k < 200) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        check("fast_frames", 32'(m2.frames), 32'd1);
        check("fast_rises",  32'(m2.last_rises), 32'd16);
        check("fast_cs_low", 32'(m2.last_cs_low), 32'd34);
        check("fast_word",   32'(m2.last_word), 32'h837E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
